sprite_cmd_scheduler: RTL and testbench
=======================================

Name: sprite_cmd_scheduler

Overview:
- Sequences the sprite finder/attribute engine and shares its function port between two command requesters: the game-logic core (requester 0) and the instruction decoder (requester 1).
- Per-pixel find requests have priority and are never delayed by a command already waiting for grant.
- Attribute commands (level, position, collision) are issued only during video blanking, one at a time, with fixed hold windows.
- Collision results are returned to the requester that issued the command.

Parameters:
- FIND_CYCLES, 8, cycles the engine is held busy after a find launch (range 2..255).
- CMD_CYCLES, 3, cycles the engine is held busy after a level or position command (range 2..255).
- COLL_TIMEOUT, 8, maximum cycles to wait for a collision answer (range 2..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- video_on  in  1  1 = active display; commands are blocked while high
- find_req  in  1  one-cycle pulse requesting a pixel find
- find_done  out  1  one-cycle pulse when the find window ends
- find_overrun  out  1  one-cycle pulse when a find request is lost
- cmd_valid  in  2  per-requester command valid
- cmd_data0  in  34  requester 0 command: [33:32] selector, [31:26] level/input01, [25:20] id/input02, [19:10] col, [9:0] row
- cmd_data1  in  34  requester 1 command, same format
- cmd_ready  out  2  per-requester accept; combinational
- cmd_err  out  1  one-cycle pulse when selector 2'b11 is accepted and dropped
- coll_valid  out  1  one-cycle collision result strobe
- coll_hit  out  1  collision result, valid with coll_valid
- coll_owner  out  1  index of the requester that owns the result
- active_finder_position  out  1  find launch pulse to the engine
- active_function_processor  out  1  command launch pulse to the engine
- function_selector  out  2  registered command field
- function_level_sprit  out  6  registered command field
- function_id_sprit  out  6  registered command field
- function_col  out  10  registered command field
- function_row  out  10  registered command field
- function_input01  out  6  copy of the level field
- function_input02  out  6  copy of the id field
- function_sp_colision_out  in  1  collision flag from the engine

Behaviour:
- Reset (rst low, asynchronous, including mid-operation):
  - All outputs 0; state goes to IDLE.
  - Round-robin pointer resets to requester 0.
  - Pending-find flag and all counters clear.
  - Any in-flight command is abandoned and no collision result is issued for it.
- find_req handling:
  - A find_req seen in a non-IDLE state sets the pending flag.
  - A find_req arriving while the flag is already set pulses find_overrun; the request is dropped.
- IDLE priority order:
  1. find_req or pending flag set: go to FIND; active_finder_position=1 for the next cycle; clear the flag.
  2. Else, if video_on=0 and any cmd_valid: grant one requester.
     - Arbitration is round-robin: the pointer names the preferred requester and moves to the other requester after each grant.
     - cmd_ready of the granted requester = 1 in that same cycle.
     - Command is captured on that edge into the function_* registers.
     - Next state is ISSUE.
  3. Else stay in IDLE.
- cmd_ready is 1 only in IDLE with no find pending, video_on=0, and the requester granted. Requesters hold data stable until ready.
- FIND: hold FIND_CYCLES cycles counted from the launch cycle; on the last cycle pulse find_done and return to IDLE.
- ISSUE (1 cycle): active_function_processor=1.
  - Selector 00 or 01: go to WAIT.
  - Selector 10: go to COLL.
  - Selector 11: no launch, pulse cmd_err, return to IDLE.
- WAIT: hold CMD_CYCLES, then IDLE. Cannot be interrupted; find_req only sets the pending flag.
- COLL: count cycles.
  - First cycle with function_sp_colision_out=1: coll_valid=1, coll_hit=1, coll_owner=granted index, then IDLE.
  - Reaching COLL_TIMEOUT with no answer: coll_valid=1, coll_hit=0, then IDLE.
- Launch latency:
  - Find launch: active_finder_position exactly 1 cycle after find_req when in IDLE.
  - Command launch: ISSUE is the cycle after the handshake.
- video_on rising during WAIT or COLL does not abort the command.
- Simultaneous events in IDLE: find_req together with cmd_valid gives the find; the command waits and the pointer is unchanged.
- Both requesters valid: pointer decides; strict alternation when both stay valid.

Optional Feature:
- Macro SCHED_CMD_COUNT_EN.
- When defined, adds outputs cmd_count0 and cmd_count1 (16 bits each).
  - Each counts accepted commands for its requester, including dropped 11 commands.
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then find_req pulse in IDLE -> active_finder_position high 1 cycle later; find_done 8 cycles after launch; no other activity.
- video_on=0, requester 0 sends selector 01, col 10'd100, row 10'd50 -> cmd_ready[0] same cycle; next cycle active_function_processor=1 with function_col=100, function_row=50; IDLE after 3 more cycles.
- Both requesters valid continuously, four commands each -> grants alternate 0,1,0,1...; none granted while video_on=1.
- Collision command with engine flag raised 3 cycles after launch -> coll_valid, coll_hit=1, coll_owner correct; repeat with no flag -> coll_valid with coll_hit=0 after 8 cycles.
- During WAIT, find_req twice -> first find launched right after WAIT ends, find_overrun pulses once; selector 11 -> cmd_err, no launch.
- Assert rst low mid-COLL -> all outputs 0 immediately, no coll_valid after release, next grant goes to requester 0.

Source files
------------

// File: rtl/sprite_cmd_scheduler.sv
// sprite_cmd_scheduler: shares the sprite engine between pixel finds and two blanking-only command requesters.
// Optional per-requester accepted-command counters when SCHED_CMD_COUNT_EN is defined.
module sprite_cmd_scheduler #(
    parameter int FIND_CYCLES  = 8,
    parameter int CMD_CYCLES   = 3,
    parameter int COLL_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        video_on,
    input  logic        find_req,
    output logic        find_done,
    output logic        find_overrun,
    input  logic [1:0]  cmd_valid,
    input  logic [33:0] cmd_data0,
    input  logic [33:0] cmd_data1,
    output logic [1:0]  cmd_ready,
    output logic        cmd_err,
    output logic        coll_valid,
    output logic        coll_hit,
    output logic        coll_owner,
    output logic        active_finder_position,
    output logic        active_function_processor,
    output logic [1:0]  function_selector,
    output logic [5:0]  function_level_sprit,
    output logic [5:0]  function_id_sprit,
    output logic [9:0]  function_col,
    output logic [9:0]  function_row,
    output logic [5:0]  function_input01,
    output logic [5:0]  function_input02,
`ifdef SCHED_CMD_COUNT_EN
    output logic [15:0] cmd_count0,
    output logic [15:0] cmd_count1,
`endif
    input  logic        function_sp_colision_out
);
    typedef enum logic [2:0] {IDLE, FIND, ISSUE, WAIT, COLL} state_t;

    localparam logic [7:0] FIND_LAST = 8'(FIND_CYCLES - 1);
    localparam logic [7:0] CMD_LAST  = 8'(CMD_CYCLES - 1);
    localparam logic [7:0] COLL_LAST = 8'(COLL_TIMEOUT - 1);

    state_t      state;
    logic        pending;
    logic        ptr;
    logic        gnt_q;
    logic [7:0]  cnt;
    logic        take_find;
    logic        grant_ok;
    logic        gnt;
    logic [33:0] sel_data;

    always_comb begin
        take_find = find_req | pending;
        gnt       = cmd_valid[ptr] ? ptr : ~ptr;
        grant_ok  = rst && state == IDLE && !take_find && !video_on && |cmd_valid;
        cmd_ready = {grant_ok & gnt, grant_ok & ~gnt};
        sel_data  = gnt ? cmd_data1 : cmd_data0;
    end

    assign function_input01 = function_level_sprit;
    assign function_input02 = function_id_sprit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                     <= IDLE;
            pending                   <= 1'b0;
            ptr                       <= 1'b0;
            gnt_q                     <= 1'b0;
            cnt                       <= '0;
            find_done                 <= 1'b0;
            find_overrun              <= 1'b0;
            cmd_err                   <= 1'b0;
            coll_valid                <= 1'b0;
            coll_hit                  <= 1'b0;
            coll_owner                <= 1'b0;
            active_finder_position    <= 1'b0;
            active_function_processor <= 1'b0;
            function_selector         <= '0;
            function_level_sprit      <= '0;
            function_id_sprit         <= '0;
            function_col              <= '0;
            function_row              <= '0;
        end else begin
            find_done                 <= 1'b0;
            cmd_err                   <= 1'b0;
            coll_valid                <= 1'b0;
            coll_hit                  <= 1'b0;
            active_finder_position    <= 1'b0;
            active_function_processor <= 1'b0;
            find_overrun              <= find_req & pending;
            pending                   <= state == IDLE ? 1'b0 : pending | find_req;
            case (state)
                IDLE: begin
                    if (take_find) begin
                        state                  <= FIND;
                        active_finder_position <= 1'b1;
                        cnt                    <= '0;
                    end else if (grant_ok) begin
                        state                     <= ISSUE;
                        gnt_q                     <= gnt;
                        ptr                       <= ~gnt;
                        function_selector         <= sel_data[33:32];
                        function_level_sprit      <= sel_data[31:26];
                        function_id_sprit         <= sel_data[25:20];
                        function_col              <= sel_data[19:10];
                        function_row              <= sel_data[9:0];
                        active_function_processor <= sel_data[33:32] != 2'b11;
                        cmd_err                   <= sel_data[33:32] == 2'b11;
                    end
                end
                FIND: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == FIND_LAST) begin
                        find_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= function_selector == 2'b11 ? IDLE :
                             function_selector == 2'b10 ? COLL : WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == CMD_LAST) state <= IDLE;
                end
                COLL: begin
                    cnt <= cnt + 8'd1;
                    // the engine answer wins over a timeout landing in the same cycle
                    if (function_sp_colision_out || cnt == COLL_LAST) begin
                        coll_valid <= 1'b1;
                        coll_hit   <= function_sp_colision_out;
                        coll_owner <= gnt_q;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCHED_CMD_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_count0 <= '0;
            cmd_count1 <= '0;
        end else begin
            if (cmd_ready[0] && cmd_count0 != 16'hFFFF) cmd_count0 <= cmd_count0 + 16'd1;
            if (cmd_ready[1] && cmd_count1 != 16'hFFFF) cmd_count1 <= cmd_count1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// tb_sprite_cmd_scheduler: vector table plus scoreboard bench for sprite_cmd_scheduler.
module tb_sprite_cmd_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        video_on = 1'b0;
    logic        find_req = 1'b0;
    logic        find_done, find_overrun;
    logic [1:0]  cmd_valid = 2'b00;
    logic [33:0] cmd_data0 = '0;
    logic [33:0] cmd_data1 = '0;
    logic [1:0]  cmd_ready;
    logic        cmd_err, coll_valid, coll_hit, coll_owner;
    logic        afp, afpr;
    logic [1:0]  fsel;
    logic [5:0]  flvl, fid, fin01, fin02;
    logic [9:0]  fcol, frow;
    logic        colision = 1'b0;
    logic [55:0] all_out;

    sprite_cmd_scheduler dut (
        .clk(clk), .rst(rst), .video_on(video_on),
        .find_req(find_req), .find_done(find_done), .find_overrun(find_overrun),
        .cmd_valid(cmd_valid), .cmd_data0(cmd_data0), .cmd_data1(cmd_data1),
        .cmd_ready(cmd_ready), .cmd_err(cmd_err),
        .coll_valid(coll_valid), .coll_hit(coll_hit), .coll_owner(coll_owner),
        .active_finder_position(afp), .active_function_processor(afpr),
        .function_selector(fsel), .function_level_sprit(flvl), .function_id_sprit(fid),
        .function_col(fcol), .function_row(frow),
        .function_input01(fin01), .function_input02(fin02),
        .function_sp_colision_out(colision)
    );

    always #5 clk = ~clk;

    assign all_out = {find_done, find_overrun, cmd_ready, cmd_err, coll_valid, coll_hit, coll_owner,
                      afp, afpr, fsel, flvl, fid, fcol, frow, fin01, fin02};

    typedef struct {
        int         r;
        logic [1:0] sel;
        logic [5:0] lvl;
        logic [5:0] id;
        logic [9:0] col;
        logic [9:0] row;
        int         cd;
        int         gap;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [5:0] lvl;
        logic [5:0] id;
        logic [9:0] col;
        logic [9:0] row;
    } exp_cmd_t;

    typedef struct {
        logic hit;
        logic owner;
    } exp_coll_t;

    exp_cmd_t  cq[$];
    exp_coll_t kq[$];
    int total = 0;
    int bad = 0;
    logic ptr_m = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] s, input logic [5:0] l, input logic [5:0] i,
                            input logic [9:0] c, input logic [9:0] rw);
        exp_cmd_t e;
        e.sel = s; e.lvl = l; e.id = i; e.col = c; e.row = rw;
        cq.push_back(e);
    endtask

    task automatic push_coll(input logic h, input logic o);
        exp_coll_t k;
        k.hit = h; k.owner = o;
        kq.push_back(k);
    endtask

    // counts cycles until a grant is offered, pulsing the engine flag cd+1 cycles after the handshake
    task automatic wait_ready(input int cd, output int n);
        n = 0;
        #1;
        while (cmd_ready == 2'b00 && n < 40) begin
            colision = (cd >= 0 && n == cd + 1);
            tick();
            colision = 1'b0;
            #1;
            n++;
        end
    endtask

    always @(posedge clk) begin
        exp_cmd_t  e;
        exp_coll_t k;
        #1;
        if (afpr || cmd_err) begin
            if (cq.size() == 0) check("unexpected_cmd", {62'd0, afpr, cmd_err}, 64'd0);
            else begin
                e = cq.pop_front();
                check("launch", {62'd0, afpr, cmd_err}, {62'd0, e.sel != 2'b11, e.sel == 2'b11});
                check("fields", {18'd0, fsel, flvl, fid, fcol, frow, fin01, fin02},
                      {18'd0, e.sel, e.lvl, e.id, e.col, e.row, e.lvl, e.id});
            end
        end
        if (coll_valid) begin
            if (kq.size() == 0) check("unexpected_coll", {63'd0, coll_valid}, 64'd0);
            else begin
                k = kq.pop_front();
                check("coll", {62'd0, coll_hit, coll_owner}, {62'd0, k.hit, k.owner});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   n;
        int   prev_gap;
        int   prev_cd;
        vt[0] = '{0, 2'd1, 6'd5,  6'd9,  10'd100,  10'd50,  -1, 4};
        vt[1] = '{1, 2'd0, 6'd63, 6'd0,  10'd1023, 10'd0,   -1, 4};
        vt[2] = '{0, 2'd2, 6'd1,  6'd2,  10'd3,    10'd4,    2, 4};
        vt[3] = '{1, 2'd2, 6'd7,  6'd8,  10'd512,  10'd511, -1, 9};
        vt[4] = '{1, 2'd3, 6'd33, 6'd44, 10'd5,    10'd6,   -1, 1};
        vt[5] = '{0, 2'd2, 6'd10, 6'd11, 10'd12,   10'd13,   0, 2};
        vt[6] = '{1, 2'd1, 6'd20, 6'd21, 10'd22,   10'd23,  -1, 4};

        tick(); tick();
        check("reset_outputs", {8'd0, all_out}, 64'd0);
        rst = 1'b1;
        tick();

        find_req = 1'b1;
        tick();
        find_req = 1'b0;
        check("find_launch", {63'd0, afp}, 64'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("find_done", {63'd0, find_done}, {63'd0, i == 8});
            check("find_quiet", {61'd0, afp, afpr, coll_valid}, 64'd0);
        end

        prev_gap = 0;
        prev_cd  = -1;
        for (int v = 0; v < 7; v++) begin
            if (vt[v].r == 0) cmd_data0 = {vt[v].sel, vt[v].lvl, vt[v].id, vt[v].col, vt[v].row};
            else              cmd_data1 = {vt[v].sel, vt[v].lvl, vt[v].id, vt[v].col, vt[v].row};
            cmd_valid = 2'(1 << vt[v].r);
            wait_ready(prev_cd, n);
            check("vec_gap", 64'(n), 64'(prev_gap));
            check("vec_ready", {62'd0, cmd_ready}, 64'(1 << vt[v].r));
            push_cmd(vt[v].sel, vt[v].lvl, vt[v].id, vt[v].col, vt[v].row);
            if (vt[v].sel == 2'd2) push_coll(vt[v].cd >= 0, vt[v].r[0]);
            ptr_m = ~vt[v].r[0];
            tick();
            cmd_valid = 2'b00;
            prev_gap = vt[v].gap;
            prev_cd  = vt[v].cd;
        end
        repeat (prev_gap + 1) tick();

        video_on  = 1'b1;
        cmd_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("video_block", {62'd0, cmd_ready}, 64'd0);
        end
        video_on = 1'b0;
        for (int g = 0; g < 8; g++) begin
            cmd_data0 = {2'd1, 6'd3, 6'd4, 10'(100 + g), 10'd0};
            cmd_data1 = {2'd1, 6'd3, 6'd4, 10'(100 + g), 10'd1};
            wait_ready(-1, n);
            check("rr_gap", 64'(n), g == 0 ? 64'd0 : 64'd4);
            check("rr_grant", {62'd0, cmd_ready}, ptr_m ? 64'd2 : 64'd1);
            push_cmd(2'd1, 6'd3, 6'd4, 10'(100 + g), {9'd0, ptr_m});
            tick();
            ptr_m = ~ptr_m;
        end
        cmd_valid = 2'b00;
        repeat (5) tick();

        cmd_data0 = {2'd0, 6'd1, 6'd1, 10'd7, 10'd7};
        cmd_data1 = {2'd0, 6'd1, 6'd1, 10'd7, 10'd7};
        cmd_valid = 2'b11;
        find_req  = 1'b1;
        #1;
        check("find_beats_cmd", {62'd0, cmd_ready}, 64'd0);
        tick();
        find_req = 1'b0;
        check("find_first", {63'd0, afp}, 64'd1);
        wait_ready(-1, n);
        check("cmd_after_find", 64'(n), 64'd8);
        check("ptr_kept", {62'd0, cmd_ready}, ptr_m ? 64'd2 : 64'd1);
        push_cmd(2'd0, 6'd1, 6'd1, 10'd7, 10'd7);
        tick();
        ptr_m = ~ptr_m;
        cmd_valid = 2'b00;
        repeat (5) tick();

        cmd_data0 = {2'd0, 6'd2, 6'd3, 10'd20, 10'd21};
        cmd_valid = 2'b01;
        wait_ready(-1, n);
        check("wait_ready", {62'd0, cmd_ready}, 64'd1);
        push_cmd(2'd0, 6'd2, 6'd3, 10'd20, 10'd21);
        tick();
        cmd_valid = 2'b00;
        for (int c = 1; c <= 14; c++) begin
            tick();
            find_req = (c == 1 || c == 3);
            check("overrun", {63'd0, find_overrun}, {63'd0, c == 4});
            check("pend_launch", {63'd0, afp}, {63'd0, c == 5});
            check("pend_done", {63'd0, find_done}, {63'd0, c == 13});
        end
        find_req = 1'b0;

        cmd_data1 = {2'd2, 6'd9, 6'd9, 10'd1, 10'd2};
        cmd_valid = 2'b10;
        wait_ready(-1, n);
        check("coll_ready", {62'd0, cmd_ready}, 64'd2);
        push_cmd(2'd2, 6'd9, 6'd9, 10'd1, 10'd2);
        tick();
        cmd_valid = 2'b00;
        tick(); tick();
        rst = 1'b0;
        cmd_data0 = {2'd1, 6'd4, 6'd5, 10'd55, 10'd66};
        cmd_valid = 2'b11;
        #1;
        check("async_reset", {8'd0, all_out}, 64'd0);
        tick(); tick();
        rst = 1'b1;
        ptr_m = 1'b0;
        wait_ready(-1, n);
        check("post_reset_gap", 64'(n), 64'd0);
        check("post_reset_grant", {62'd0, cmd_ready}, 64'd1);
        push_cmd(2'd1, 6'd4, 6'd5, 10'd55, 10'd66);
        tick();
        cmd_valid = 2'b00;
        repeat (12) tick();
        check("cmd_queue_empty", 64'(cq.size()), 64'd0);
        check("coll_queue_empty", 64'(kq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
